// File: rtl/vm_txn_ctrl_if.sv
// Vending transaction controller bus: coin acceptor, buttons, dispenser and hopper signals.
// The master side is the machine environment; the slave side is the controller.
interface vm_txn_ctrl_if;
  logic       coin_valid;
  logic [3:0] coin_val;
  logic       sel_a;
  logic       sel_b;
  logic       cancel;
  logic       vend_ack;
  logic       vend_req;
  logic       vend_sel;
  logic       change_pulse;
  logic       change_done;
  logic [3:0] credit;
  logic       insuff;
  logic       coin_reject;
  logic       busy;

  modport master (
    output coin_valid, coin_val, sel_a, sel_b, cancel, vend_ack,
    input  vend_req, vend_sel, change_pulse, change_done, credit, insuff, coin_reject, busy
  );

  modport slave (
    input  coin_valid, coin_val, sel_a, sel_b, cancel, vend_ack,
    output vend_req, vend_sel, change_pulse, change_done, credit, insuff, coin_reject, busy
  );
endinterface

// File: rtl/vm_txn_ctrl.sv
// Vending machine transaction controller: credit accumulation, A/B selection arbitration,
// dispenser handshake and unit-pulse change payout. All outputs are registered.
module vm_txn_ctrl #(
  parameter int unsigned PRICE_A = 5,
  parameter int unsigned PRICE_B = 10,
  parameter int unsigned TIMEOUT = 200
) (
  input logic          clk,
  input logic          reset,
  vm_txn_ctrl_if.slave bus
);

  localparam int unsigned TmoW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);
  localparam logic [3:0] PriceA = 4'(PRICE_A);
  localparam logic [3:0] PriceB = 4'(PRICE_B);

  typedef enum logic [1:0] {StIdle, StCredit, StVend, StChange} state_e;

  state_e          state_q, state_d;
  logic [3:0]      credit_q, credit_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            ptr_b_q, ptr_b_d;
  logic            sel_a_q, sel_a_d;
  logic            sel_b_q, sel_b_d;
  logic            vend_req_q, vend_req_d;
  logic            vend_sel_q, vend_sel_d;
  logic            change_pulse_q, change_pulse_d;
  logic            change_done_q, change_done_d;
  logic            insuff_q, insuff_d;
  logic            coin_reject_q, coin_reject_d;
  logic            busy_q, busy_d;

  logic       coin_in, coin_fits, coin_ok;
  logic [4:0] coin_sum;
  logic       edge_a, edge_b, btn, pick_b, afford;
  logic [3:0] price;

  always_comb begin
    coin_in   = bus.coin_valid && (bus.coin_val != 4'd0);
    coin_sum  = {1'b0, credit_q} + {1'b0, bus.coin_val};
    coin_fits = coin_sum <= 5'd15;
    coin_ok   = coin_in && coin_fits;
    edge_a    = bus.sel_a && !sel_a_q;
    edge_b    = bus.sel_b && !sel_b_q;
    btn       = edge_a || edge_b;
    // On a simultaneous press the pointer decides; a lone press always wins.
    pick_b    = edge_b && (!edge_a || ptr_b_q);
    price     = pick_b ? PriceB : PriceA;
    afford    = credit_q >= price;
  end

  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    tmo_d          = '0;
    ptr_b_d        = ptr_b_q;
    sel_a_d        = bus.sel_a;
    sel_b_d        = bus.sel_b;
    vend_req_d     = vend_req_q;
    vend_sel_d     = vend_sel_q;
    change_pulse_d = 1'b0;
    change_done_d  = 1'b0;
    insuff_d       = 1'b0;
    coin_reject_d  = 1'b0;

    unique case (state_q)
      StIdle, StCredit: begin
        if (state_q == StCredit && !coin_ok && !btn) tmo_d = tmo_q + 1'b1;
        if (state_q == StCredit && bus.cancel) begin
          // A coin arriving with cancel is still taken and refunded with the rest.
          state_d        = StChange;
          change_pulse_d = 1'b1;
          tmo_d          = '0;
          if (coin_ok) credit_d = coin_sum[3:0];
          coin_reject_d = coin_in && !coin_fits;
        end else if (btn && afford) begin
          state_d       = StVend;
          credit_d      = credit_q - price;
          vend_req_d    = 1'b1;
          vend_sel_d    = pick_b;
          ptr_b_d       = !pick_b;
          coin_reject_d = coin_in;
        end else begin
          insuff_d = btn;
          if (coin_ok) begin
            credit_d = coin_sum[3:0];
            state_d  = StCredit;
          end else begin
            coin_reject_d = coin_in;
            if (state_q == StCredit && !btn && tmo_q == TmoLast) begin
              state_d        = StChange;
              change_pulse_d = 1'b1;
              tmo_d          = '0;
            end
          end
        end
      end
      StVend: begin
        coin_reject_d = coin_in;
        if (bus.vend_ack) begin
          vend_req_d = 1'b0;
          if (credit_q != 4'd0) begin
            state_d        = StChange;
            change_pulse_d = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StChange: begin
        coin_reject_d = coin_in;
        if (change_pulse_q) begin
          credit_d = credit_q - 4'd1;
          if (credit_q == 4'd1) begin
            change_done_d = 1'b1;
            state_d       = StIdle;
          end
        end else begin
          change_pulse_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StVend) || (state_d == StChange);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= StIdle;
      credit_q       <= '0;
      tmo_q          <= '0;
      ptr_b_q        <= 1'b0;
      sel_a_q        <= 1'b0;
      sel_b_q        <= 1'b0;
      vend_req_q     <= 1'b0;
      vend_sel_q     <= 1'b0;
      change_pulse_q <= 1'b0;
      change_done_q  <= 1'b0;
      insuff_q       <= 1'b0;
      coin_reject_q  <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      tmo_q          <= tmo_d;
      ptr_b_q        <= ptr_b_d;
      sel_a_q        <= sel_a_d;
      sel_b_q        <= sel_b_d;
      vend_req_q     <= vend_req_d;
      vend_sel_q     <= vend_sel_d;
      change_pulse_q <= change_pulse_d;
      change_done_q  <= change_done_d;
      insuff_q       <= insuff_d;
      coin_reject_q  <= coin_reject_d;
      busy_q         <= busy_d;
    end
  end

  assign bus.credit       = credit_q;
  assign bus.vend_req     = vend_req_q;
  assign bus.vend_sel     = vend_sel_q;
  assign bus.change_pulse = change_pulse_q;
  assign bus.change_done  = change_done_q;
  assign bus.insuff       = insuff_q;
  assign bus.coin_reject  = coin_reject_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_vm_txn_ctrl.sv
// Directed bench for vm_txn_ctrl: coin, select, arbitration, timeout, payout and reset cases.
module tb_vm_txn_ctrl;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  vm_txn_ctrl_if bus ();

  vm_txn_ctrl #(
    .PRICE_A (5),
    .PRICE_B (10),
    .TIMEOUT (200)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic coin(input logic [3:0] v);
    bus.coin_valid = 1'b1;
    bus.coin_val   = v;
    cyc();
    bus.coin_valid = 1'b0;
    bus.coin_val   = 4'd0;
  endtask

  task automatic ack();
    bus.vend_ack = 1'b1;
    cyc();
    bus.vend_ack = 1'b0;
  endtask

  // Called while sampling the first CHANGE cycle; counts pulses until change_done.
  task automatic pay(input string tag, input int n);
    int  pulses;
    int  span;
    bit  done;
    pulses = 1;
    span   = 1;
    done   = 1'b0;
    chk({tag, "_first_pulse"}, 16'(bus.change_pulse), 16'd1);
    for (int i = 0; i < 4 * n + 4; i++) begin
      cyc();
      if (bus.change_done) begin
        done = 1'b1;
        break;
      end
      if (bus.change_pulse) pulses++;
      span++;
    end
    chk({tag, "_done"}, 16'(done), 16'd1);
    chk({tag, "_pulses"}, 16'(pulses), 16'(n));
    chk({tag, "_span"}, 16'(span), 16'(2 * n - 1));
    chk({tag, "_credit0"}, 16'(bus.credit), 16'd0);
    chk({tag, "_idle"}, 16'(bus.busy), 16'd0);
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    reset          = 1'b0;
    bus.coin_valid = 1'b0;
    bus.coin_val   = 4'd0;
    bus.sel_a      = 1'b0;
    bus.sel_b      = 1'b0;
    bus.cancel     = 1'b0;
    bus.vend_ack   = 1'b0;
    cyc();
    cyc();
    chk("rst_credit", 16'(bus.credit), 16'd0);
    chk("rst_outs", 16'({bus.vend_req, bus.vend_sel, bus.change_pulse, bus.change_done,
                         bus.insuff, bus.coin_reject, bus.busy}), 16'd0);
    reset = 1'b1;
    cyc();

    // Coins 5 + 10, select B, pay 5 change
    coin(4'd5);
    chk("t1_credit5", 16'(bus.credit), 16'd5);
    coin(4'd10);
    chk("t1_credit15", 16'(bus.credit), 16'd15);
    bus.sel_b = 1'b1;
    cyc();
    chk("t1_vend_req", 16'(bus.vend_req), 16'd1);
    chk("t1_vend_sel", 16'(bus.vend_sel), 16'd1);
    chk("t1_credit_after", 16'(bus.credit), 16'd5);
    chk("t1_busy", 16'(bus.busy), 16'd1);
    bus.sel_b = 1'b0;
    cyc();
    chk("t1_req_held", 16'(bus.vend_req), 16'd1);
    ack();
    chk("t1_req_drop", 16'(bus.vend_req), 16'd0);
    pay("t1", 5);

    // Insufficient credit, then cancel refund
    coin(4'd3);
    bus.sel_a = 1'b1;
    cyc();
    chk("t2_insuff", 16'(bus.insuff), 16'd1);
    chk("t2_no_vend", 16'(bus.vend_req), 16'd0);
    chk("t2_credit3", 16'(bus.credit), 16'd3);
    bus.sel_a = 1'b0;
    cyc();
    chk("t2_insuff_pulse", 16'(bus.insuff), 16'd0);
    bus.cancel = 1'b1;
    cyc();
    bus.cancel = 1'b0;
    pay("t2", 3);

    // Overflow reject, then coin during VEND
    coin(4'd12);
    chk("t3_credit12", 16'(bus.credit), 16'd12);
    coin(4'd5);
    chk("t3_reject", 16'(bus.coin_reject), 16'd1);
    chk("t3_credit_kept", 16'(bus.credit), 16'd12);
    cyc();
    chk("t3_reject_pulse", 16'(bus.coin_reject), 16'd0);
    bus.sel_a = 1'b1;
    cyc();
    bus.sel_a = 1'b0;
    chk("t3_vend_a", 16'({bus.vend_req, bus.vend_sel}), 16'b10);
    chk("t3_credit7", 16'(bus.credit), 16'd7);
    coin(4'd1);
    chk("t3_reject_vend", 16'(bus.coin_reject), 16'd1);
    chk("t3_credit7_kept", 16'(bus.credit), 16'd7);
    ack();
    pay("t3", 7);

    // Arbitration after reset: A first, then B
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
    coin(4'd15);
    bus.sel_a = 1'b1;
    bus.sel_b = 1'b1;
    cyc();
    bus.sel_a = 1'b0;
    bus.sel_b = 1'b0;
    chk("t4_grant_a", 16'({bus.vend_req, bus.vend_sel}), 16'b10);
    chk("t4_credit10", 16'(bus.credit), 16'd10);
    ack();
    pay("t4a", 10);
    coin(4'd15);
    bus.sel_a = 1'b1;
    bus.sel_b = 1'b1;
    cyc();
    bus.sel_a = 1'b0;
    bus.sel_b = 1'b0;
    chk("t4_grant_b", 16'({bus.vend_req, bus.vend_sel}), 16'b11);
    chk("t4_credit5", 16'(bus.credit), 16'd5);
    ack();
    pay("t4b", 5);

    // Idle timeout refund
    coin(4'd2);
    for (int i = 0; i < 199; i++) cyc();
    chk("t5_not_yet", 16'(bus.busy), 16'd0);
    chk("t5_credit2", 16'(bus.credit), 16'd2);
    cyc();
    chk("t5_timeout", 16'(bus.busy), 16'd1);
    pay("t5", 2);

    // Asynchronous reset during VEND
    coin(4'd10);
    bus.sel_a = 1'b1;
    cyc();
    bus.sel_a = 1'b0;
    chk("t6_vend", 16'(bus.vend_req), 16'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_async_req", 16'(bus.vend_req), 16'd0);
    chk("t6_async_credit", 16'(bus.credit), 16'd0);
    chk("t6_async_busy", 16'(bus.busy), 16'd0);
    cyc();
    reset = 1'b1;
    ack();
    chk("t6_ack_ignored", 16'({bus.vend_req, bus.change_pulse, bus.busy}), 16'd0);
    cyc();
    chk("t6_no_change", 16'({bus.change_pulse, bus.change_done}), 16'd0);
    chk("t6_credit0", 16'(bus.credit), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
